// File: rtl/mod8_seq_monitor_if.sv
// Bundle between a mod-8 counter source (master) and mod8_seq_monitor (slave).
// err_exp/err_got exist only when MOD8_MON_ERRCAP_EN is defined.
interface mod8_seq_monitor_if #(
    parameter int WRAP_W = 8,
    parameter int ERR_W  = 4
);
    logic [2:0]        count_in;
    logic              valid;
    logic              clr;
    logic              wrap_pulse;
    logic [WRAP_W-1:0] wrap_cnt;
    logic [ERR_W-1:0]  err_cnt;
    logic              fault;
    logic              locked;
`ifdef MOD8_MON_ERRCAP_EN
    logic [2:0]        err_exp;
    logic [2:0]        err_got;

    modport master (
        output count_in, valid, clr,
        input  wrap_pulse, wrap_cnt, err_cnt, fault, locked, err_exp, err_got
    );

    modport slave (
        input  count_in, valid, clr,
        output wrap_pulse, wrap_cnt, err_cnt, fault, locked, err_exp, err_got
    );
`else
    modport master (
        output count_in, valid, clr,
        input  wrap_pulse, wrap_cnt, err_cnt, fault, locked
    );

    modport slave (
        input  count_in, valid, clr,
        output wrap_pulse, wrap_cnt, err_cnt, fault, locked
    );
`endif
endinterface

// File: rtl/mod8_seq_monitor.sv
// Checks that qualified samples of a mod-8 count advance by one, counts wraps and errors.
// Optional error capture (err_exp/err_got) is enabled by defining MOD8_MON_ERRCAP_EN.
module mod8_seq_monitor #(
    parameter int WRAP_W     = 8,
    parameter int ERR_W      = 4,
    parameter int ERR_LIMIT  = 3,
    parameter int ALLOW_HOLD = 1
) (
    input  logic                clk,
    input  logic                rst,
    mod8_seq_monitor_if.slave   mon
);

    typedef enum logic [1:0] {
        ST_SYNC  = 2'd0,
        ST_TRACK = 2'd1,
        ST_FAULT = 2'd2
    } state_e;

    localparam logic [ERR_W:0] ERR_LIMIT_C = (ERR_W+1)'(ERR_LIMIT);

    function automatic logic [WRAP_W-1:0] wrap_sat_inc(input logic [WRAP_W-1:0] v);
        return (v == {WRAP_W{1'b1}}) ? v : v + WRAP_W'(1);
    endfunction

    function automatic logic [ERR_W-1:0] err_sat_inc(input logic [ERR_W-1:0] v);
        return (v == {ERR_W{1'b1}}) ? v : v + ERR_W'(1);
    endfunction

    state_e            state_q, state_d;
    logic [2:0]        prev_q, prev_d;
    logic [WRAP_W-1:0] wrap_cnt_q, wrap_cnt_d;
    logic [ERR_W-1:0]  err_cnt_q, err_cnt_d;
    logic              wrap_pulse_q, wrap_pulse_d;
    logic              fault_q, fault_d;
    logic              locked_q, locked_d;
`ifdef MOD8_MON_ERRCAP_EN
    logic [2:0]        err_exp_q, err_exp_d;
    logic [2:0]        err_got_q, err_got_d;
`endif

    logic [2:0]        exp_s;
    logic [ERR_W:0]    err_next_s;
    logic              is_adv_s;
    logic              is_hold_s;
    logic              err_reach_s;

    // Next-state, counter and output decode for the tracking FSM
    always_comb begin
        state_d      = state_q;
        prev_d       = prev_q;
        wrap_cnt_d   = wrap_cnt_q;
        err_cnt_d    = err_cnt_q;
        wrap_pulse_d = 1'b0;
`ifdef MOD8_MON_ERRCAP_EN
        err_exp_d    = err_exp_q;
        err_got_d    = err_got_q;
`endif
        exp_s        = prev_q + 3'd1;
        is_adv_s     = (mon.count_in == exp_s);
        is_hold_s    = (ALLOW_HOLD != 0) && (mon.count_in == prev_q);
        // Unsaturated next error count, so the limit test sees err_cnt+1 even at saturation
        err_next_s   = {1'b0, err_cnt_q} + (ERR_W+1)'(1);
        err_reach_s  = (err_next_s >= ERR_LIMIT_C);

        if (mon.clr) begin
            state_d    = ST_SYNC;
            prev_d     = 3'd0;
            wrap_cnt_d = '0;
            err_cnt_d  = '0;
`ifdef MOD8_MON_ERRCAP_EN
            err_exp_d  = 3'd0;
            err_got_d  = 3'd0;
`endif
        end else if (mon.valid) begin
            case (state_q)
                ST_SYNC: begin
                    prev_d  = mon.count_in;
                    state_d = ST_TRACK;
                end
                ST_TRACK: begin
                    prev_d = mon.count_in;
                    if (is_adv_s) begin
                        if (prev_q == 3'd7) begin
                            wrap_pulse_d = 1'b1;
                            wrap_cnt_d   = wrap_sat_inc(wrap_cnt_q);
                        end else begin
                            wrap_cnt_d   = wrap_cnt_q;
                        end
                    end else if (is_hold_s) begin
                        err_cnt_d = err_cnt_q;
                    end else begin
                        err_cnt_d = err_sat_inc(err_cnt_q);
`ifdef MOD8_MON_ERRCAP_EN
                        err_exp_d = exp_s;
                        err_got_d = mon.count_in;
`endif
                        if (err_reach_s) begin
                            state_d = ST_FAULT;
                        end else begin
                            state_d = ST_TRACK;
                        end
                    end
                end
                ST_FAULT: begin
                    state_d = ST_FAULT;
                end
                default: begin
                    state_d = ST_SYNC;
                    prev_d  = 3'd0;
                end
            endcase
        end else begin
            state_d = state_q;
        end

        locked_d = (state_d == ST_TRACK);
        fault_d  = (state_d == ST_FAULT);
    end

    // State, counters and registered outputs; reset is synchronous and overrides clr/valid
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= ST_SYNC;
            prev_q       <= 3'd0;
            wrap_cnt_q   <= '0;
            err_cnt_q    <= '0;
            wrap_pulse_q <= 1'b0;
            fault_q      <= 1'b0;
            locked_q     <= 1'b0;
`ifdef MOD8_MON_ERRCAP_EN
            err_exp_q    <= 3'd0;
            err_got_q    <= 3'd0;
`endif
        end else begin
            state_q      <= state_d;
            prev_q       <= prev_d;
            wrap_cnt_q   <= wrap_cnt_d;
            err_cnt_q    <= err_cnt_d;
            wrap_pulse_q <= wrap_pulse_d;
            fault_q      <= fault_d;
            locked_q     <= locked_d;
`ifdef MOD8_MON_ERRCAP_EN
            err_exp_q    <= err_exp_d;
            err_got_q    <= err_got_d;
`endif
        end
    end

    assign mon.wrap_pulse = wrap_pulse_q;
    assign mon.wrap_cnt   = wrap_cnt_q;
    assign mon.err_cnt    = err_cnt_q;
    assign mon.fault      = fault_q;
    assign mon.locked     = locked_q;
`ifdef MOD8_MON_ERRCAP_EN
    assign mon.err_exp    = err_exp_q;
    assign mon.err_got    = err_got_q;
`endif

endmodule

// File: tb/tb_mod8_seq_monitor.sv
// Directed bench for mod8_seq_monitor: default, no-hold and 2-bit-wrap instances share one stimulus.
module tb_mod8_seq_monitor;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] cnt_s;
    logic       valid_s;
    logic       clr_s;
    int         n_checks = 0;
    int         n_errors = 0;
    int         pulses_a = 0;
    int         pulses_c = 0;

    always #5 clk = ~clk;

    mod8_seq_monitor_if #(.WRAP_W(8), .ERR_W(4)) if_a ();
    mod8_seq_monitor_if #(.WRAP_W(8), .ERR_W(4)) if_b ();
    mod8_seq_monitor_if #(.WRAP_W(2), .ERR_W(4)) if_c ();

    assign if_a.count_in = cnt_s;
    assign if_a.valid    = valid_s;
    assign if_a.clr      = clr_s;
    assign if_b.count_in = cnt_s;
    assign if_b.valid    = valid_s;
    assign if_b.clr      = clr_s;
    assign if_c.count_in = cnt_s;
    assign if_c.valid    = valid_s;
    assign if_c.clr      = clr_s;

    mod8_seq_monitor #(.WRAP_W(8), .ERR_W(4), .ERR_LIMIT(3), .ALLOW_HOLD(1)) dut_a (
        .clk(clk), .rst(rst), .mon(if_a));
    mod8_seq_monitor #(.WRAP_W(8), .ERR_W(4), .ERR_LIMIT(3), .ALLOW_HOLD(0)) dut_b (
        .clk(clk), .rst(rst), .mon(if_b));
    mod8_seq_monitor #(.WRAP_W(2), .ERR_W(4), .ERR_LIMIT(3), .ALLOW_HOLD(1)) dut_c (
        .clk(clk), .rst(rst), .mon(if_c));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // One clock: drive at negedge, sample 1ns after the rising edge
    task automatic cyc(input logic v, input logic [2:0] c, input logic cl);
        @(negedge clk);
        valid_s = v;
        cnt_s   = c;
        clr_s   = cl;
        @(posedge clk);
        #1;
        if (if_a.wrap_pulse === 1'b1) pulses_a++;
        if (if_c.wrap_pulse === 1'b1) pulses_c++;
    endtask

    initial begin
        rst     = 1'b0;
        cnt_s   = 3'd0;
        valid_s = 1'b0;
        clr_s   = 1'b0;
        cyc(1'b0, 3'd0, 1'b0);
        cyc(1'b0, 3'd0, 1'b0);
        chk("rst_wrap_pulse", 32'(if_a.wrap_pulse), 32'd0);
        chk("rst_wrap_cnt",   32'(if_a.wrap_cnt),   32'd0);
        chk("rst_err_cnt",    32'(if_a.err_cnt),    32'd0);
        chk("rst_fault",      32'(if_a.fault),      32'd0);
        chk("rst_locked",     32'(if_a.locked),     32'd0);
        rst = 1'b1;

        // Two full laps plus the closing 0
        cyc(1'b1, 3'd0, 1'b0);
        chk("sync_locked", 32'(if_a.locked), 32'd1);
        chk("sync_wrap",   32'(if_a.wrap_cnt), 32'd0);
        for (int k = 1; k <= 16; k++) begin
            cyc(1'b1, 3'(k % 8), 1'b0);
        end
        chk("lap_pulses",   32'(pulses_a),       32'd2);
        chk("lap_wrap_a",   32'(if_a.wrap_cnt),  32'd2);
        chk("lap_err_a",    32'(if_a.err_cnt),   32'd0);
        chk("lap_fault_a",  32'(if_a.fault),     32'd0);
        chk("lap_locked_a", 32'(if_a.locked),    32'd1);
        chk("lap_wrap_c",   32'(if_c.wrap_cnt),  32'd2);
        chk("lap_err_b",    32'(if_b.err_cnt),   32'd0);
        cyc(1'b0, 3'd3, 1'b0);
        chk("idle_pulse",  32'(if_a.wrap_pulse), 32'd0);
        chk("idle_wrap",   32'(if_a.wrap_cnt),   32'd2);
        chk("idle_locked", 32'(if_a.locked),     32'd1);

        // Skip from 3 to 5, then re-referenced 6 is legal
        cyc(1'b0, 3'd0, 1'b1);
        chk("clr_wrap",   32'(if_a.wrap_cnt), 32'd0);
        chk("clr_locked", 32'(if_a.locked),   32'd0);
        for (int k = 0; k <= 3; k++) begin
            cyc(1'b1, 3'(k), 1'b0);
        end
        cyc(1'b1, 3'd5, 1'b0);
        chk("skip_err",    32'(if_a.err_cnt), 32'd1);
        chk("skip_locked", 32'(if_a.locked),  32'd1);
`ifdef MOD8_MON_ERRCAP_EN
        chk("skip_err_exp", 32'(if_a.err_exp), 32'd4);
        chk("skip_err_got", 32'(if_a.err_got), 32'd5);
`endif
        cyc(1'b1, 3'd6, 1'b0);
        chk("reref_err", 32'(if_a.err_cnt), 32'd1);

        // Repeat sample: legal with hold allowed, an error otherwise
        cyc(1'b0, 3'd0, 1'b1);
        cyc(1'b1, 3'd2, 1'b0);
        cyc(1'b1, 3'd2, 1'b0);
        cyc(1'b1, 3'd3, 1'b0);
        chk("hold_err_a", 32'(if_a.err_cnt), 32'd0);
        chk("hold_err_b", 32'(if_b.err_cnt), 32'd1);

        // Three errors reach the limit
        cyc(1'b0, 3'd0, 1'b1);
        cyc(1'b1, 3'd0, 1'b0);
        cyc(1'b1, 3'd4, 1'b0);
        chk("e1_err", 32'(if_a.err_cnt), 32'd1);
        cyc(1'b1, 3'd1, 1'b0);
        chk("e2_err",    32'(if_a.err_cnt), 32'd2);
        chk("e2_locked", 32'(if_a.locked),  32'd1);
        chk("e2_fault",  32'(if_a.fault),   32'd0);
        cyc(1'b1, 3'd6, 1'b0);
        chk("e3_err",    32'(if_a.err_cnt), 32'd3);
        chk("e3_fault",  32'(if_a.fault),   32'd1);
        chk("e3_locked", 32'(if_a.locked),  32'd0);
        cyc(1'b1, 3'd7, 1'b0);
        cyc(1'b1, 3'd0, 1'b0);
        chk("flt_wrap",  32'(if_a.wrap_cnt),   32'd0);
        chk("flt_err",   32'(if_a.err_cnt),    32'd3);
        chk("flt_pulse", 32'(if_a.wrap_pulse), 32'd0);
        chk("flt_fault", 32'(if_a.fault),      32'd1);

        // clr beats a coincident valid; next valid re-syncs
        cyc(1'b1, 3'd5, 1'b1);
        chk("clrv_fault",  32'(if_a.fault),    32'd0);
        chk("clrv_err",    32'(if_a.err_cnt),  32'd0);
        chk("clrv_locked", 32'(if_a.locked),   32'd0);
        chk("clrv_wrap",   32'(if_a.wrap_cnt), 32'd0);
        cyc(1'b1, 3'd3, 1'b0);
        chk("resync_locked", 32'(if_a.locked),  32'd1);
        chk("resync_err",    32'(if_a.err_cnt), 32'd0);
        cyc(1'b1, 3'd4, 1'b0);
        chk("resync_adv", 32'(if_a.err_cnt), 32'd0);

        // Five wraps saturate the 2-bit counter
        cyc(1'b0, 3'd0, 1'b1);
        pulses_a = 0;
        pulses_c = 0;
        cyc(1'b1, 3'd0, 1'b0);
        for (int w = 0; w < 5; w++) begin
            for (int k = 1; k <= 8; k++) begin
                cyc(1'b1, 3'(k % 8), 1'b0);
            end
        end
        chk("sat_wrap_c",   32'(if_c.wrap_cnt), 32'd3);
        chk("sat_pulses_c", 32'(pulses_c),      32'd5);
        chk("sat_wrap_a",   32'(if_a.wrap_cnt), 32'd5);
        chk("sat_err_c",    32'(if_c.err_cnt),  32'd0);
        cyc(1'b1, 3'd1, 1'b0);
        cyc(1'b1, 3'd2, 1'b0);
        rst = 1'b0;
        cyc(1'b1, 3'd3, 1'b0);
        chk("mid_rst_wrap_c",   32'(if_c.wrap_cnt),   32'd0);
        chk("mid_rst_err_c",    32'(if_c.err_cnt),    32'd0);
        chk("mid_rst_locked_c", 32'(if_c.locked),     32'd0);
        chk("mid_rst_fault_c",  32'(if_c.fault),      32'd0);
        chk("mid_rst_pulse_c",  32'(if_c.wrap_pulse), 32'd0);
        chk("mid_rst_wrap_a",   32'(if_a.wrap_cnt),   32'd0);
        rst = 1'b1;
        cyc(1'b1, 3'd6, 1'b0);
        chk("post_rst_locked", 32'(if_a.locked), 32'd1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
